// File: rtl/menu_nav_ctrl.sv
// Two-level UI menu controller: mode selection at level 0, per-mode field
// editing with an apply row at level 1, and held left/right auto-repeat.
module menu_nav_ctrl #(
    parameter int N_MODES    = 3,
    parameter int N_FIELDS   = 4,
    parameter int FIELD_W    = 2,
    parameter int FIELD_MAX  = 3,
    parameter int RETAIN     = 1,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000,
    localparam int MSEL_W    = (N_MODES > 1) ? $clog2(N_MODES) : 1,
    localparam int FSEL_W    = (N_FIELDS > 0) ? $clog2(N_FIELDS + 1) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_left,
    input  logic                          key_right,
    input  logic                          key_up,
    input  logic                          key_down,
    input  logic                          key_confirm,
    input  logic                          key_quit,
    input  logic                          hold_left,
    input  logic                          hold_right,
    output logic                          level,
    output logic [MSEL_W-1:0]             mode_sel,
    output logic [FSEL_W-1:0]             field_sel,
    output logic [N_FIELDS*FIELD_W-1:0]   field_vals,
    output logic                          applied,
    output logic                          apply_pulse
);

    localparam int CNT_W = $clog2(REPEAT_DLY + 1);

    typedef enum logic [1:0] {TOP, EDIT, ARMED} state_t;

    state_t                         state_q, state_d;
    logic [MSEL_W-1:0]              mode_q, mode_d;
    logic [FSEL_W-1:0]              row_q, row_d;
    logic [FIELD_W-1:0]             vals_q [N_MODES][N_FIELDS];
    logic [FIELD_W-1:0]             vals_d [N_MODES][N_FIELDS];
    logic [CNT_W-1:0]               cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
    logic [N_FIELDS*FIELD_W-1:0]    field_vals_q, field_vals_d;
    logic                           level_q, applied_q, pulse_q, pulse_d;
    logic                           on_field, rep_ok;
    logic                           step_l, step_r, go_left, go_right;
    logic                           lr_inc, lr_dec, ud_evt;
    logic                           fld_inc, fld_dec, clr_mode;

    assign on_field = (row_q != FSEL_W'(N_FIELDS));
    assign rep_ok   = (state_q == EDIT) && on_field && (hold_left ^ hold_right);

    // Next-state, navigation, field editing and auto-repeat counters.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        row_d        = row_q;
        vals_d       = vals_q;
        pulse_d      = 1'b0;
        cnt_l_d      = '0;
        cnt_r_d      = '0;
        step_l       = 1'b0;
        step_r       = 1'b0;
        fld_inc      = 1'b0;
        fld_dec      = 1'b0;
        clr_mode     = 1'b0;
        field_vals_d = '0;

        // After the first step the counter is reloaded so that it reaches the
        // trigger value again REPEAT_PER cycles later.
        if (rep_ok && hold_left) begin
            if (cnt_l_q == CNT_W'(REPEAT_DLY - 1)) begin
                step_l  = 1'b1;
                cnt_l_d = CNT_W'(REPEAT_DLY - REPEAT_PER);
            end else begin
                cnt_l_d = cnt_l_q + 1'b1;
            end
        end
        if (rep_ok && hold_right) begin
            if (cnt_r_q == CNT_W'(REPEAT_DLY - 1)) begin
                step_r  = 1'b1;
                cnt_r_d = CNT_W'(REPEAT_DLY - REPEAT_PER);
            end else begin
                cnt_r_d = cnt_r_q + 1'b1;
            end
        end

        // A pulse and a repeat step in the same direction merge into one step.
        go_left  = !(key_left && key_right) && (key_left || step_l);
        go_right = !(key_left && key_right) && (key_right || step_r);
        lr_inc   = go_right && !go_left;
        lr_dec   = go_left && !go_right;
        ud_evt   = key_up || key_down;

        // The highest-priority key present owns the cycle, even when ignored.
        case (state_q)
            TOP: begin
                if (!key_quit) begin
                    if (key_confirm) begin
                        state_d = EDIT;
                        row_d   = '0;
                    end else if (!ud_evt) begin
                        if (lr_inc)
                            mode_d = (mode_q == MSEL_W'(N_MODES - 1)) ? '0 : mode_q + 1'b1;
                        else if (lr_dec)
                            mode_d = (mode_q == '0) ? MSEL_W'(N_MODES - 1) : mode_q - 1'b1;
                    end
                end
            end
            EDIT: begin
                if (key_quit) begin
                    state_d  = TOP;
                    row_d    = '0;
                    clr_mode = (RETAIN == 0);
                end else if (key_confirm) begin
                    if (!on_field) begin
                        state_d = ARMED;
                        pulse_d = 1'b1;
                    end
                end else if (ud_evt) begin
                    if (key_down && !key_up)
                        row_d = (row_q == FSEL_W'(N_FIELDS)) ? '0 : row_q + 1'b1;
                    else if (key_up && !key_down)
                        row_d = (row_q == '0) ? FSEL_W'(N_FIELDS) : row_q - 1'b1;
                end else if (on_field) begin
                    fld_inc = lr_inc;
                    fld_dec = lr_dec;
                end
            end
            default: begin
                if (key_quit) begin
                    state_d  = TOP;
                    row_d    = '0;
                    clr_mode = (RETAIN == 0);
                end
            end
        endcase

        if ((state_d != state_q) || (row_d != row_q)) begin
            cnt_l_d = '0;
            cnt_r_d = '0;
        end

        for (int unsigned m = 0; m < N_MODES; m++) begin
            for (int unsigned f = 0; f < N_FIELDS; f++) begin
                if (mode_q == MSEL_W'(m)) begin
                    if (clr_mode)
                        vals_d[m][f] = '0;
                    else if (fld_inc && row_q == FSEL_W'(f))
                        vals_d[m][f] = (vals_q[m][f] == FIELD_W'(FIELD_MAX)) ? '0 : vals_q[m][f] + 1'b1;
                    else if (fld_dec && row_q == FSEL_W'(f))
                        vals_d[m][f] = (vals_q[m][f] == '0) ? FIELD_W'(FIELD_MAX) : vals_q[m][f] - 1'b1;
                end
            end
        end

        for (int unsigned m = 0; m < N_MODES; m++) begin
            for (int unsigned f = 0; f < N_FIELDS; f++) begin
                if (mode_d == MSEL_W'(m))
                    field_vals_d[f*FIELD_W +: FIELD_W] = vals_d[m][f];
            end
        end
    end

    // State, stored fields and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= TOP;
            mode_q       <= '0;
            row_q        <= '0;
            cnt_l_q      <= '0;
            cnt_r_q      <= '0;
            level_q      <= 1'b0;
            applied_q    <= 1'b0;
            pulse_q      <= 1'b0;
            field_vals_q <= '0;
            for (int unsigned m = 0; m < N_MODES; m++)
                for (int unsigned f = 0; f < N_FIELDS; f++)
                    vals_q[m][f] <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            row_q        <= row_d;
            cnt_l_q      <= cnt_l_d;
            cnt_r_q      <= cnt_r_d;
            level_q      <= (state_d != TOP);
            applied_q    <= (state_d == ARMED);
            pulse_q      <= pulse_d;
            field_vals_q <= field_vals_d;
            vals_q       <= vals_d;
        end
    end

    assign level       = level_q;
    assign mode_sel    = mode_q;
    assign field_sel   = row_q;
    assign field_vals  = field_vals_q;
    assign applied     = applied_q;
    assign apply_pulse = pulse_q;

endmodule
